// File: rtl/pll_lock_rstseq_if.sv
// pll_lock_rstseq_if
//   Bundles the PLL-facing and fabric-facing signals of pll_lock_rstseq.
//   master : the sequencer itself (consumes locked, drives everything else)
//   slave  : the environment (drives locked, observes the sequencer)
// Signals
//   locked   PLL lock, asynchronous to the sequencer clock
//   pll_rst  active-high reset request to the PLL
//   rst_out  active-high staged domain resets, bit 0 released first
//   ready    level status: high while every rst_out bit is deasserted.
//            There is no handshake on this interface; ready is a plain
//            status level and never waits on a consumer.
//   lost_cnt saturating count of lock-loss events
//   state    FSM state encoding, debug only
interface pll_lock_rstseq_if #(
    parameter int STAGES = 4
);
    logic              locked;
    logic              pll_rst;
    logic [STAGES-1:0] rst_out;
    logic              ready;
    logic [7:0]        lost_cnt;
    logic [2:0]        state;

    modport master (
        input  locked,
        output pll_rst,
        output rst_out,
        output ready,
        output lost_cnt,
        output state
    );

    modport slave (
        output locked,
        input  pll_rst,
        input  rst_out,
        input  ready,
        input  lost_cnt,
        input  state
    );
endinterface

// File: rtl/pll_lock_rstseq.sv
// pll_lock_rstseq
//   Turns the ECP5 PLL 'locked' output into a staged reset-release sequence.
//   Synchronizes and glitch-filters lock, re-arms the PLL with a timed reset
//   pulse when lock never arrives, and re-asserts every domain reset on
//   lock loss.
// Ports
//   clk  reference clock, all logic on its rising edge
//   rst  synchronous active-high reset
//   bus  pll_lock_rstseq_if.master (locked in; pll_rst, rst_out, ready,
//        lost_cnt, state out). All outputs come straight from flops.
module pll_lock_rstseq #(
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_FILTER  = 16,
    parameter int HOLDOFF      = 1024,
    parameter int STAGES       = 4,
    parameter int STAGE_GAP    = 16,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int PLLRST_LEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    pll_lock_rstseq_if.master bus
);
    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_PLLRST    = 3'd1;
    localparam logic [2:0] S_FILTER    = 3'd2;
    localparam logic [2:0] S_HOLDOFF   = 3'd3;
    localparam logic [2:0] S_RELEASE   = 3'd4;
    localparam logic [2:0] S_RUN       = 3'd5;

    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    // The filter counter holds the value LOCK_FILTER itself, hence the +1.
    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int PW = (PLLRST_LEN > 1) ? $clog2(PLLRST_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0]             state_q, state_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic [GW-1:0]          gcnt_q, gcnt_d;
    logic [PW-1:0]          pcnt_q, pcnt_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [STAGES-1:0]      rst_out_q, rst_out_d;
    logic                   ready_q, ready_d;
    logic [7:0]             lost_q, lost_d;
    logic                   locked_s;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], bus.locked};
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        fcnt_d    = fcnt_q;
        hcnt_d    = hcnt_q;
        gcnt_d    = gcnt_q;
        pcnt_d    = pcnt_q;
        pll_rst_d = pll_rst_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        lost_d    = lost_q;

        case (state_q)
            S_WAIT_LOCK: begin
                // Saturate so a long FILTER excursion cannot wrap the counter.
                if (tcnt_q != TW'(LOCK_TIMEOUT - 1)) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                if (locked_s) begin
                    state_d = S_FILTER;
                    fcnt_d  = FW'(1);
                end else if (tcnt_q == TW'(LOCK_TIMEOUT - 1)) begin
                    state_d   = S_PLLRST;
                    pll_rst_d = 1'b1;
                    pcnt_d    = '0;
                end
            end
            S_PLLRST: begin
                // locked_s is deliberately ignored while the PLL is held.
                if (pcnt_q == PW'(PLLRST_LEN - 1)) begin
                    state_d   = S_WAIT_LOCK;
                    pll_rst_d = 1'b0;
                    tcnt_d    = '0;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            S_FILTER: begin
                // Timeout keeps running so a flapping lock still re-arms the PLL.
                if (tcnt_q != TW'(LOCK_TIMEOUT - 1)) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (fcnt_q == FW'(LOCK_FILTER)) begin
                    state_d = S_HOLDOFF;
                    hcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            S_HOLDOFF, S_RELEASE, S_RUN: begin
                if (!locked_s) begin
                    state_d   = S_WAIT_LOCK;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                    tcnt_d    = '0;
                    lost_d    = (lost_q == 8'hFF) ? lost_q : lost_q + 1'b1;
                end else if (state_q == S_HOLDOFF) begin
                    if (hcnt_q == HW'(HOLDOFF - 1)) begin
                        // Bits release LSB first, so a left shift drops the
                        // lowest still-asserted bit.
                        rst_out_d = rst_out_q << 1;
                        gcnt_d    = '0;
                        if (rst_out_d == '0) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = S_RELEASE;
                        end
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end else if (state_q == S_RELEASE) begin
                    if (gcnt_q == GW'(STAGE_GAP - 1)) begin
                        rst_out_d = rst_out_q << 1;
                        gcnt_d    = '0;
                        if (rst_out_d == '0) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        gcnt_d = gcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_WAIT_LOCK;
                rst_out_d = '1;
                ready_d   = 1'b0;
                pll_rst_d = 1'b0;
                tcnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            state_q   <= S_WAIT_LOCK;
            tcnt_q    <= '0;
            fcnt_q    <= '0;
            hcnt_q    <= '0;
            gcnt_q    <= '0;
            pcnt_q    <= '0;
            pll_rst_q <= 1'b0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            lost_q    <= '0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            fcnt_q    <= fcnt_d;
            hcnt_q    <= hcnt_d;
            gcnt_q    <= gcnt_d;
            pcnt_q    <= pcnt_d;
            pll_rst_q <= pll_rst_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            lost_q    <= lost_d;
        end
    end

    assign bus.pll_rst  = pll_rst_q;
    assign bus.rst_out  = rst_out_q;
    assign bus.ready    = ready_q;
    assign bus.lost_cnt = lost_q;
    assign bus.state    = state_q;
endmodule
